// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmit FSM states, frame sizes, odd parity
// and the common host command bytes. Used by the TX block and its bench.
package ps2_pkg;

   localparam int PS2_FRAME_BITS = 11;
   localparam int PS2_DATA_BITS  = 8;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_ACK          = 8'hFA;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_e;

   // 1 when the byte holds an even number of ones, so the
   // nine bits {parity, data} always carry an odd count.
   function automatic logic odd_parity(
      input logic [PS2_DATA_BITS-1:0] d
   );
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte handshake into the PS/2 transmitter.
// Ports: tx_data (byte), tx_valid (byte present), tx_ready (idle/accepting).
interface ps2_host_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pad conditioning: 2-flop synchronizers, optional clock filter
// (PS2_HOST_TX_FILTER_EN) and clock falling-edge strobe.
// Ports: i_clk, i_reset, i_ps2_clk, i_ps2_data (raw pads);
//        o_clk_s, o_data_s (conditioned levels), o_clk_fall (1-cycle strobe).
module ps2_line_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_ps2_clk,
   input  logic i_ps2_data,
   output logic o_clk_s,
   output logic o_data_s,
   output logic o_clk_fall
);

   logic r_clk_meta;
   logic r_clk_sync;
   logic r_data_meta;
   logic r_data_sync;
   logic r_clk_prev;
   logic w_clk_src;

   // Idle bus is high, so the chain resets to 1 and never
   // reports a spurious fall when reset is released.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_clk_meta  <= i_ps2_clk;
         r_clk_sync  <= r_clk_meta;
         r_data_meta <= i_ps2_data;
         r_data_sync <= r_data_meta;
      end
   end

`ifdef PS2_HOST_TX_FILTER_EN
   logic [3:0] r_hist;
   logic       r_clk_filt;

   // Output follows only after four identical samples in a row;
   // shorter pulses leave the filtered level untouched.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_hist     <= 4'hF;
         r_clk_filt <= 1'b1;
      end else begin
         r_hist <= {r_hist[2:0], r_clk_sync};
         if (&r_hist) begin
            r_clk_filt <= 1'b1;
         end else if (~|r_hist) begin
            r_clk_filt <= 1'b0;
         end
      end
   end

   assign w_clk_src = r_clk_filt;
`else
   assign w_clk_src = r_clk_sync;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_clk_prev <= 1'b1;
      end else begin
         r_clk_prev <= w_clk_src;
      end
   end

   assign o_clk_s    = w_clk_src;
   assign o_data_s   = r_data_sync;
   assign o_clk_fall = r_clk_prev & ~w_clk_src;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop, then device ACK check, with a timeout.
// Ports: clk, reset (sync, active high); tx_if (slave: tx_data/tx_valid/
//   tx_ready); ps2_clk_in/ps2_data_in raw pads; ps2_clk_oe/ps2_data_oe
//   (1 = pull low); busy; done, ack_err, timeout_err one-cycle pulses.
// Option: PS2_HOST_TX_FILTER_EN adds a 4-sample filter on the PS/2 clock.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 750_000
) (
   input  logic           clk,
   input  logic           reset,
   ps2_host_tx_if.slave   tx_if,
   input  logic           ps2_clk_in,
   input  logic           ps2_data_in,
   output logic           ps2_clk_oe,
   output logic           ps2_data_oe,
   output logic           busy,
   output logic           done,
   output logic           ack_err,
   output logic           timeout_err
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                            INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] INH_RTS  = CW'(INHIBIT_CYCLES - 2);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    STOP_IDX = 4'(PS2_DATA_BITS + 1);

   if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || CLK_HZ < 1)
   begin : g_bad_param
      $error("ps2_host_tx: invalid parameters");
   end

   ps2_tx_state_e r_state;
   logic [CW-1:0] r_cnt;
   logic [8:0]    r_shift;
   logic [3:0]    r_bit_idx;
   logic          r_clk_oe;
   logic          r_data_oe;
   logic          r_ready;
   logic          r_done;
   logic          r_ack_err;
   logic          r_timeout_err;
   logic          r_ack_bad;

   logic w_clk_s;
   logic w_data_s;
   logic w_fall;
   logic w_timeout;

   ps2_line_sync u_sync (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_ps2_clk  (ps2_clk_in),
      .i_ps2_data (ps2_data_in),
      .o_clk_s    (w_clk_s),
      .o_data_s   (w_data_s),
      .o_clk_fall (w_fall)
   );

   // The timeout covers everything after the clock is released.
   assign w_timeout = (r_state == ST_SEND ||
                       r_state == ST_ACK  ||
                       r_state == ST_WAIT_IDLE) &&
                      (r_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_shift       <= '0;
         r_bit_idx     <= '0;
         r_clk_oe      <= 1'b0;
         r_data_oe     <= 1'b0;
         r_ready       <= 1'b1;
         r_done        <= 1'b0;
         r_ack_err     <= 1'b0;
         r_timeout_err <= 1'b0;
         r_ack_bad     <= 1'b0;
      end else begin
         r_done        <= 1'b0;
         r_ack_err     <= 1'b0;
         r_timeout_err <= 1'b0;
         if (w_timeout) begin
            r_clk_oe      <= 1'b0;
            r_data_oe     <= 1'b0;
            r_done        <= 1'b1;
            r_timeout_err <= 1'b1;
            r_ready       <= 1'b1;
            r_state       <= ST_IDLE;
         end else begin
            unique case (r_state)
               ST_IDLE: begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_ready   <= 1'b1;
                  if (tx_if.tx_valid && r_ready) begin
                     r_shift  <= {odd_parity(tx_if.tx_data),
                                  tx_if.tx_data};
                     r_cnt    <= '0;
                     r_clk_oe <= 1'b1;
                     r_ready  <= 1'b0;
                     r_state  <= ST_INHIBIT;
                  end
               end
               ST_INHIBIT: begin
                  // Start bit goes low one cycle before the clock
                  // is released, giving the one-cycle overlap.
                  if (r_cnt == INH_LAST) begin
                     r_clk_oe  <= 1'b0;
                     r_cnt     <= '0;
                     r_bit_idx <= '0;
                     r_state   <= ST_SEND;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                     if (r_cnt == INH_RTS) begin
                        r_data_oe <= 1'b1;
                     end
                  end
               end
               ST_SEND: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_fall) begin
                     if (r_bit_idx == STOP_IDX) begin
                        r_data_oe <= 1'b0;
                        r_state   <= ST_ACK;
                     end else begin
                        r_data_oe <= ~r_shift[0];
                        r_shift   <= {1'b0, r_shift[8:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                     end
                  end
               end
               ST_ACK: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_fall) begin
                     r_ack_bad <= w_data_s;
                     r_state   <= ST_WAIT_IDLE;
                  end
               end
               ST_WAIT_IDLE: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_clk_s && w_data_s) begin
                     r_done    <= 1'b1;
                     r_ack_err <= r_ack_bad;
                     r_ready   <= 1'b1;
                     r_state   <= ST_IDLE;
                  end
               end
               default: begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_ready   <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign tx_if.tx_ready = r_ready;
   assign busy           = ~r_ready;
   assign ps2_clk_oe     = r_clk_oe;
   assign ps2_data_oe    = r_data_oe;
   assign done           = r_done;
   assign ack_err        = r_ack_err;
   assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on wired-AND pads,
// frame reference built from the byte, directed and random sends.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 100;
   localparam int TO  = 2000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic clk_oe, data_oe, busy, done, ack_err, timeout_err;
   logic pad_clk, pad_data;
   int   n_tests = 0;
   int   n_fail = 0;
   int   done_cnt = 0;

   always #5 clk = ~clk;

   assign pad_clk  = dev_clk & ~clk_oe;
   assign pad_data = dev_data & ~data_oe;

   ps2_host_tx_if tx_if ();

   ps2_host_tx #(
      .CLK_HZ         (50_000_000),
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tx_if       (tx_if),
      .ps2_clk_in  (pad_clk),
      .ps2_data_in (pad_data),
      .ps2_clk_oe  (clk_oe),
      .ps2_data_oe (data_oe),
      .busy        (busy),
      .done        (done),
      .ack_err     (ack_err),
      .timeout_err (timeout_err)
   );

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample order: start, d0..d7, parity, stop.
   function automatic logic [10:0] ref_frame(input logic [7:0] d);
      int ones;
      logic par;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      par = (ones % 2 == 0);
      return {1'b1, par, d, 1'b0};
   endfunction

   task automatic accept(input logic [7:0] d);
      check("ready_pre", {31'd0, tx_if.tx_ready}, 1);
      tx_if.tx_data  = d;
      tx_if.tx_valid = 1'b1;
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'($urandom);
      check("busy_after_accept", {31'd0, busy}, 1);
   endtask

   task automatic inhibit_phase();
      int n;
      int nd;
      n = 0;
      nd = 0;
      while (clk_oe === 1'b1 && n < INH * 4) begin
         n++;
         if (data_oe === 1'b1) nd++;
         @(negedge clk);
      end
      check("inhibit_len", n, INH);
      check("rts_overlap", nd, 1);
      check("start_drv", {31'd0, data_oe}, 1);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit ack,
                             input int h, input int abort_k,
                             input int busy_k, input int glitch_k);
      logic [10:0] got;
      int m;
      int dc0;
      dc0 = done_cnt;
      accept(d);
      inhibit_phase();
      repeat (h) @(negedge clk);
      got = '0;
      got[0] = pad_data;
      for (int k = 1; k <= 11; k++) begin
         if (k == abort_k) begin
            reset = 1'b1;
            @(negedge clk);
            check("rst_clk_oe", {31'd0, clk_oe}, 0);
            check("rst_data_oe", {31'd0, data_oe}, 0);
            check("rst_ready", {31'd0, tx_if.tx_ready}, 1);
            check("rst_done", {31'd0, done}, 0);
            reset = 1'b0;
            repeat (5) @(negedge clk);
            check("rst_no_done", done_cnt - dc0, 0);
            return;
         end
         if (k == 11 && ack) begin
            dev_data = 1'b0;
            repeat (5) @(negedge clk);
         end
         dev_clk = 1'b0;
         if (k == busy_k) begin
            repeat (2) @(negedge clk);
            tx_if.tx_data  = 8'h55;
            tx_if.tx_valid = 1'b1;
            @(negedge clk);
            tx_if.tx_valid = 1'b0;
            repeat (h - 3) @(negedge clk);
         end else begin
            repeat (h) @(negedge clk);
         end
         dev_clk = 1'b1;
         if (k <= 10) got[k] = pad_data;
         if (k == 11) break;
         if (k == glitch_k) begin
            repeat (h / 2) @(negedge clk);
            dev_clk = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b1;
            repeat (h - h / 2 - 2) @(negedge clk);
         end else begin
            repeat (h) @(negedge clk);
         end
      end
      dev_data = 1'b1;
      check("frame_bits", {21'd0, got}, {21'd0, ref_frame(d)});
      m = 0;
      while (done !== 1'b1 && m < 50) begin
         @(negedge clk);
         m++;
      end
      check("done_seen", {31'd0, done}, 1);
      check("ack_err", {31'd0, ack_err}, {31'd0, !ack});
      check("to_err_clear", {31'd0, timeout_err}, 0);
      check("ready_back", {31'd0, tx_if.tx_ready}, 1);
      repeat (3) @(negedge clk);
      check("idle_oe", {30'd0, clk_oe, data_oe}, 0);
      check("one_done", done_cnt - dc0, 1);
   endtask

   task automatic timeout_frame(input logic [7:0] d);
      int k;
      accept(d);
      inhibit_phase();
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (done !== 1'b1 && k < TO + 100);
      check("timeout_at", k, TO);
      check("timeout_err", {31'd0, timeout_err}, 1);
      check("timeout_ack", {31'd0, ack_err}, 0);
      check("timeout_oe", {30'd0, clk_oe, data_oe}, 0);
      @(negedge clk);
      check("timeout_ready", {31'd0, tx_if.tx_ready}, 1);
   endtask

   initial begin
      tx_if.tx_data  = 8'h00;
      tx_if.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_oe", {30'd0, clk_oe, data_oe}, 0);
      check("reset_pulses", {29'd0, done, ack_err, timeout_err}, 0);
      check("reset_ready", {30'd0, tx_if.tx_ready, busy}, 2);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_ready", {31'd0, tx_if.tx_ready}, 1);

      send_frame(PS2_CMD_SET_LEDS, 1'b1, 25, 0, 0, 0);
      send_frame(PS2_CMD_ENABLE, 1'b0, 25, 0, 0, 0);
      timeout_frame(8'h00);
      send_frame(8'hA3, 1'b1, 25, 6, 0, 0);
      send_frame(8'hFF, 1'b1, 25, 0, 0, 0);
      send_frame(PS2_ACK, 1'b1, 25, 0, 3, 0);
`ifdef PS2_HOST_TX_FILTER_EN
      send_frame(8'hA5, 1'b1, 25, 0, 0, 4);
`endif
      for (int i = 0; i < 6; i++) begin
         send_frame(8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)),
                    $urandom_range(20, 40), 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
